// File: rtl/wt_dcache_store_wbuf_if.sv
// Purpose : bundles the store-unit, memory-adapter and load-check signals of the write-through D$ store buffer.
// Latency : wires only; timing is set by wt_dcache_store_wbuf.
// Backpr. : st_ready_o throttles the store unit; mem_gnt_i/mem_ack_i pace the drain side.
//
// Modports: slave  = the store buffer
//           master = store unit / memory adapter / load unit environment
// Signals : st_*  store request (valid/ready, word-aligned byte-masked)
//           mem_* drain request (req/gnt), write ack (ack + TID)
//           ld_*  load hazard check and optional forwarding; empty_o = all entries free
interface wt_dcache_store_wbuf_if #(
  parameter int XLEN  = 32,
  parameter int TID_W = 2
);
  logic                st_valid_i;
  logic                st_ready_o;
  logic [XLEN-1:0]     st_addr_i;
  logic [XLEN-1:0]     st_data_i;
  logic [XLEN/8-1:0]   st_be_i;
  logic                mem_req_o;
  logic                mem_gnt_i;
  logic [XLEN-1:0]     mem_addr_o;
  logic [XLEN-1:0]     mem_data_o;
  logic [XLEN/8-1:0]   mem_be_o;
  logic [TID_W-1:0]    mem_tid_o;
  logic                mem_ack_i;
  logic [TID_W-1:0]    mem_ack_tid_i;
  logic [XLEN-1:0]     ld_addr_i;
  logic                ld_hit_o;
  logic [XLEN-1:0]     ld_data_o;
  logic [XLEN/8-1:0]   ld_fwd_be_o;
  logic                empty_o;

  modport slave (
    input  st_valid_i, st_addr_i, st_data_i, st_be_i,
    input  mem_gnt_i, mem_ack_i, mem_ack_tid_i, ld_addr_i,
    output st_ready_o, mem_req_o, mem_addr_o, mem_data_o, mem_be_o, mem_tid_o,
    output ld_hit_o, ld_data_o, ld_fwd_be_o, empty_o
  );

  modport master (
    output st_valid_i, st_addr_i, st_data_i, st_be_i,
    output mem_gnt_i, mem_ack_i, mem_ack_tid_i, ld_addr_i,
    input  st_ready_o, mem_req_o, mem_addr_o, mem_data_o, mem_be_o, mem_tid_o,
    input  ld_hit_o, ld_data_o, ld_fwd_be_o, empty_o
  );
endinterface

// File: rtl/wt_dcache_store_wbuf.sv
// Purpose : write-through D$ store buffer: merges word stores, drains them in age order with TID-tagged requests.
// Latency : store accepted at cycle N -> earliest mem_req_o at N+1; entry/TID freed by ack usable the cycle after.
// Backpr. : st_ready_o drops when no FREE entry and no mergeable entry; mem_* held stable until mem_gnt_i.
//
// Ports   : clk_i, rst_i (async active-high); bus = wt_dcache_store_wbuf_if.slave
//           (st_* store in, mem_* drain out / ack in, ld_* hazard check, empty_o).
// Option  : WBUF_LD_FWD_EN defined -> ld_data_o/ld_fwd_be_o forward the youngest matching
//           entry (VALID preferred over INFLIGHT); undefined -> both tied to zero.
module wt_dcache_store_wbuf #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TID_W = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  wt_dcache_store_wbuf_if.slave bus
);
  localparam int BE_W = XLEN / 8;
  localparam int IW   = XLEN - 2;
  localparam int NT   = 1 << TID_W;
  localparam int EW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {E_FREE = 2'd0, E_VALID = 2'd1, E_INFL = 2'd2} ent_st_e;

  // Entry storage. r_older[i][j] = entry i was allocated before entry j; this single
  // relation gives both the drain head and the youngest match for forwarding.
  ent_st_e          r_st    [DEPTH];
  logic [IW-1:0]    r_idx   [DEPTH];
  logic [XLEN-1:0]  r_dat   [DEPTH];
  logic [BE_W-1:0]  r_be    [DEPTH];
  logic [TID_W-1:0] r_tid   [DEPTH];
  logic [DEPTH-1:0] r_older [DEPTH];
  logic [NT-1:0]    r_tid_busy;
  logic             r_req;
  logic [EW-1:0]    r_req_ent;
  logic [XLEN-1:0]  r_mem_addr;
  logic [XLEN-1:0]  r_mem_data;
  logic [BE_W-1:0]  r_mem_be;
  logic [TID_W-1:0] r_mem_tid;
  logic             r_seen_gnt;

  logic [IW-1:0]    w_st_idx;
  logic [IW-1:0]    w_ld_idx;
  logic [XLEN-1:0]  w_st_mask;
  logic [DEPTH-1:0] w_is_head, w_merge_vec, w_free_vec, w_ack_vec, w_ld_match;
  logic [EW-1:0]    w_merge_ent, w_alloc_ent;
  logic             w_merge_hit, w_any_free, w_st_ready, w_acc, w_gnt, w_hold, w_ack_ok;
  logic             w_unused_bits;

  ent_st_e          w_st_n    [DEPTH];
  logic [IW-1:0]    w_idx_n   [DEPTH];
  logic [XLEN-1:0]  w_dat_n   [DEPTH];
  logic [BE_W-1:0]  w_be_n    [DEPTH];
  logic [TID_W-1:0] w_tid_n   [DEPTH];
  logic [DEPTH-1:0] w_older_n [DEPTH];
  logic [NT-1:0]    w_tid_busy_n;
  logic [DEPTH-1:0] w_is_head_n;
  logic [EW-1:0]    w_head_n;
  logic [TID_W-1:0] w_tid_sel;
  logic             w_issue;

  assign w_st_idx      = bus.st_addr_i[XLEN-1:2];
  assign w_ld_idx      = bus.ld_addr_i[XLEN-1:2];
  assign w_unused_bits = ^{bus.st_addr_i[1:0], bus.ld_addr_i[1:0]};

  always_comb begin
    w_st_mask = '0;
    for (int b = 0; b < BE_W; b++) w_st_mask[8*b +: 8] = {8{bus.st_be_i[b]}};
  end

  assign w_gnt    = r_req & bus.mem_gnt_i;
  assign w_hold   = r_req & ~bus.mem_gnt_i;
  // Acks for a TID nobody holds (e.g. stale responses after reset) are dropped here.
  assign w_ack_ok = bus.mem_ack_i & r_tid_busy[bus.mem_ack_tid_i];

  // Current-state decode. The head is never a merge target, so the data it is
  // (or will be) requesting with never changes under an outstanding request.
  always_comb begin
    w_is_head   = '0;
    w_merge_vec = '0;
    w_free_vec  = '0;
    w_ack_vec   = '0;
    w_ld_match  = '0;
    for (int j = 0; j < DEPTH; j++) begin
      w_free_vec[j] = (r_st[j] == E_FREE);
      w_is_head[j]  = (r_st[j] == E_VALID);
      for (int i = 0; i < DEPTH; i++)
        if (i != j && r_st[i] == E_VALID && r_older[i][j]) w_is_head[j] = 1'b0;
      w_merge_vec[j] = (r_st[j] == E_VALID) && !w_is_head[j] && (r_idx[j] == w_st_idx);
      w_ack_vec[j]   = w_ack_ok && (r_st[j] == E_INFL) && (r_tid[j] == bus.mem_ack_tid_i);
      w_ld_match[j]  = (r_st[j] != E_FREE) && (r_idx[j] == w_ld_idx);
    end
  end

  always_comb begin
    w_merge_ent = '0;
    w_alloc_ent = '0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (w_merge_vec[j]) w_merge_ent = EW'(j);
      if (w_free_vec[j])  w_alloc_ent = EW'(j);
    end
  end

  assign w_merge_hit = |w_merge_vec;
  assign w_any_free  = |w_free_vec;
  assign w_st_ready  = w_merge_hit | w_any_free;
  assign w_acc       = bus.st_valid_i & w_st_ready;

  // Next state: ack, grant and store all apply in the same cycle. They touch
  // disjoint entries: ack hits INFLIGHT, grant hits the head, store hits a non-head
  // VALID entry or an entry that is FREE before this edge.
  always_comb begin
    w_st_n       = r_st;
    w_idx_n      = r_idx;
    w_dat_n      = r_dat;
    w_be_n       = r_be;
    w_tid_n      = r_tid;
    w_older_n    = r_older;
    w_tid_busy_n = r_tid_busy;
    if (w_ack_ok) w_tid_busy_n[bus.mem_ack_tid_i] = 1'b0;
    for (int j = 0; j < DEPTH; j++)
      if (w_ack_vec[j]) w_st_n[j] = E_FREE;
    if (w_gnt) begin
      w_st_n[r_req_ent]       = E_INFL;
      w_tid_n[r_req_ent]      = r_mem_tid;
      w_tid_busy_n[r_mem_tid] = 1'b1;
    end
    if (w_acc) begin
      if (w_merge_hit) begin
        w_dat_n[w_merge_ent] = (r_dat[w_merge_ent] & ~w_st_mask) | (bus.st_data_i & w_st_mask);
        w_be_n[w_merge_ent]  = r_be[w_merge_ent] | bus.st_be_i;
      end else begin
        w_st_n[w_alloc_ent]    = E_VALID;
        w_idx_n[w_alloc_ent]   = w_st_idx;
        w_dat_n[w_alloc_ent]   = bus.st_data_i & w_st_mask;
        w_be_n[w_alloc_ent]    = bus.st_be_i;
        // The new entry is younger than every occupied entry.
        w_older_n[w_alloc_ent] = '0;
        for (int i = 0; i < DEPTH; i++)
          w_older_n[i][w_alloc_ent] = (r_st[i] != E_FREE) && (EW'(i) != w_alloc_ent);
      end
    end
  end

  // Request for the next cycle is chosen from the post-edge state, which is what
  // makes mem_req_o registered yet still one cycle behind the accepting store.
  always_comb begin
    w_is_head_n = '0;
    w_head_n    = '0;
    w_tid_sel   = '0;
    for (int j = 0; j < DEPTH; j++) begin
      w_is_head_n[j] = (w_st_n[j] == E_VALID);
      for (int i = 0; i < DEPTH; i++)
        if (i != j && w_st_n[i] == E_VALID && w_older_n[i][j]) w_is_head_n[j] = 1'b0;
    end
    for (int j = DEPTH - 1; j >= 0; j--)
      if (w_is_head_n[j]) w_head_n = EW'(j);
    for (int t = NT - 1; t >= 0; t--)
      if (!w_tid_busy_n[t]) w_tid_sel = TID_W'(t);
  end

  assign w_issue = (|w_is_head_n) && !(&w_tid_busy_n);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int j = 0; j < DEPTH; j++) begin
        r_st[j]    <= E_FREE;
        r_idx[j]   <= '0;
        r_dat[j]   <= '0;
        r_be[j]    <= '0;
        r_tid[j]   <= '0;
        r_older[j] <= '0;
      end
      r_tid_busy <= '0;
      r_req      <= 1'b0;
      r_req_ent  <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_be   <= '0;
      r_mem_tid  <= '0;
      r_seen_gnt <= 1'b0;
    end else begin
      r_st       <= w_st_n;
      r_idx      <= w_idx_n;
      r_dat      <= w_dat_n;
      r_be       <= w_be_n;
      r_tid      <= w_tid_n;
      r_older    <= w_older_n;
      r_tid_busy <= w_tid_busy_n;
      if (w_gnt) r_seen_gnt <= 1'b1;
      if (!w_hold) begin
        r_req      <= w_issue;
        r_req_ent  <= w_issue ? w_head_n : '0;
        r_mem_addr <= w_issue ? {w_idx_n[w_head_n], 2'b00} : '0;
        r_mem_data <= w_issue ? w_dat_n[w_head_n] : '0;
        r_mem_be   <= w_issue ? w_be_n[w_head_n] : '0;
        r_mem_tid  <= w_issue ? w_tid_sel : '0;
      end
    end
  end

  assign bus.st_ready_o = w_st_ready;
  assign bus.mem_req_o  = r_req;
  assign bus.mem_addr_o = r_mem_addr;
  assign bus.mem_data_o = r_mem_data;
  assign bus.mem_be_o   = r_mem_be;
  assign bus.mem_tid_o  = r_mem_tid;
  assign bus.empty_o    = &w_free_vec;
  assign bus.ld_hit_o   = |w_ld_match;

`ifdef WBUF_LD_FWD_EN
  logic [DEPTH-1:0] w_ld_vld, w_ld_set;
  logic [EW-1:0]    w_ld_sel;

  // Youngest match wins; VALID entries hold newer bytes than INFLIGHT ones.
  always_comb begin
    w_ld_vld = '0;
    for (int j = 0; j < DEPTH; j++) w_ld_vld[j] = w_ld_match[j] && (r_st[j] == E_VALID);
    w_ld_set = (|w_ld_vld) ? w_ld_vld : w_ld_match;
    w_ld_sel = '0;
    for (int j = 0; j < DEPTH; j++)
      if (w_ld_set[j] && !(|(r_older[j] & w_ld_set))) w_ld_sel = EW'(j);
  end

  assign bus.ld_data_o   = (|w_ld_set) ? r_dat[w_ld_sel] : '0;
  assign bus.ld_fwd_be_o = (|w_ld_set) ? r_be[w_ld_sel] : '0;
`else
  assign bus.ld_data_o   = '0;
  assign bus.ld_fwd_be_o = '0;
`endif

  // Until the first grant after reset, stray acks are taken as leftovers from
  // before the reset and are silently dropped; afterwards they indicate a bug.
  a_ack_tid_known: assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.mem_ack_i && r_seen_gnt) |-> r_tid_busy[bus.mem_ack_tid_i]);

endmodule

// File: tb/tb_wt_dcache_store_wbuf.sv
// Purpose : self-checking bench for wt_dcache_store_wbuf (directed stores, grants, acks, resets).
// Latency : expected drain requests are queued at stimulus time and popped by a monitor on each req&gnt.
// Backpr. : gnt/ack are driven by the stimulus process; ready is checked directly where it matters.
module tb_wt_dcache_store_wbuf;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [1:0]  tid;
  } txn_t;

`ifdef WBUF_LD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wt_dcache_store_wbuf_if #(.XLEN(32), .TID_W(2)) bus ();

  wt_dcache_store_wbuf #(.XLEN(32), .DEPTH(2), .TID_W(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  txn_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_req(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be, input logic [1:0] tid);
    exp_q.push_back({a, d, be, tid});
  endtask

  // One-cycle store; ready must be high for it to be accepted.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.st_valid_i = 1'b1;
    bus.st_addr_i  = a;
    bus.st_data_i  = d;
    bus.st_be_i    = be;
    #1;
    chk("st_ready_on_store", {31'd0, bus.st_ready_o}, 32'd1);
    tick();
    bus.st_valid_i = 1'b0;
  endtask

  task automatic do_ack(input logic [1:0] tid);
    bus.mem_ack_i     = 1'b1;
    bus.mem_ack_tid_i = tid;
    tick();
    bus.mem_ack_i     = 1'b0;
  endtask

  // Scoreboard monitor: every accepted drain request is compared with the queue head.
  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      if (!rst && bus.mem_req_o && bus.mem_gnt_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL mem_unexpected: got request addr 0x%08h, expected none", bus.mem_addr_o);
        end else begin
          t = exp_q.pop_front();
          chk("mem_addr", bus.mem_addr_o, t.addr);
          chk("mem_data", bus.mem_data_o, t.data);
          chk("mem_be",   {28'd0, bus.mem_be_o}, {28'd0, t.be});
          chk("mem_tid",  {30'd0, bus.mem_tid_o}, {30'd0, t.tid});
        end
      end
    end
  end

  initial begin
    bus.st_valid_i    = 1'b0;
    bus.st_addr_i     = '0;
    bus.st_data_i     = '0;
    bus.st_be_i       = '0;
    bus.mem_gnt_i     = 1'b0;
    bus.mem_ack_i     = 1'b0;
    bus.mem_ack_tid_i = '0;
    bus.ld_addr_i     = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;

    // Reset state
    chk("rst_st_ready", {31'd0, bus.st_ready_o}, 32'd1);
    chk("rst_mem_req",  {31'd0, bus.mem_req_o}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
    chk("rst_mem_data", bus.mem_data_o, 32'd0);
    chk("rst_mem_be",   {28'd0, bus.mem_be_o}, 32'd0);
    chk("rst_ld_hit",   {31'd0, bus.ld_hit_o}, 32'd0);
    chk("rst_ld_data",  bus.ld_data_o, 32'd0);
    chk("rst_ld_be",    {28'd0, bus.ld_fwd_be_o}, 32'd0);
    chk("rst_empty",    {31'd0, bus.empty_o}, 32'd1);

    // 1: single store, request one cycle later, granted next cycle
    do_store(32'h8000_0010, 32'hAABB_CCDD, 4'hF);
    chk("t1_req_at_n1", {31'd0, bus.mem_req_o}, 32'd1);
    chk("t1_req_addr",  bus.mem_addr_o, 32'h8000_0010);
    chk("t1_req_tid",   {30'd0, bus.mem_tid_o}, 32'd0);
    expect_req(32'h8000_0010, 32'hAABB_CCDD, 4'hF, 2'd0);
    bus.mem_gnt_i = 1'b1;
    tick();
    bus.mem_gnt_i = 1'b0;
    chk("t1_req_drop", {31'd0, bus.mem_req_o}, 32'd0);
    chk("t1_not_empty", {31'd0, bus.empty_o}, 32'd0);

    // 5: load hazard against the INFLIGHT entry
    bus.ld_addr_i = 32'h8000_0012;
    #1;
    chk("t5_ld_hit",  {31'd0, bus.ld_hit_o}, 32'd1);
    chk("t5_ld_be",   {28'd0, bus.ld_fwd_be_o}, FWD ? 32'h0000_000F : 32'd0);
    chk("t5_ld_data", bus.ld_data_o, FWD ? 32'hAABB_CCDD : 32'd0);
    do_ack(2'd0);
    chk("t1_empty_after_ack", {31'd0, bus.empty_o}, 32'd1);
    chk("t5_ld_miss_after_ack", {31'd0, bus.ld_hit_o}, 32'd0);

    // 2: stalled head, second entry allocated, buffer full
    do_store(32'h8000_0010, 32'h1111_1111, 4'hF);
    do_store(32'h0000_0010, 32'h0000_00AB, 4'h1);
    bus.st_valid_i = 1'b1;
    bus.st_addr_i  = 32'h0000_0014;
    bus.st_data_i  = 32'h0000_CD00;
    bus.st_be_i    = 4'h2;
    #1;
    chk("t2_full_ready", {31'd0, bus.st_ready_o}, 32'd0);
    chk("t2_head_addr",  bus.mem_addr_o, 32'h8000_0010);
    chk("t2_head_data",  bus.mem_data_o, 32'h1111_1111);
    chk("t2_head_be",    {28'd0, bus.mem_be_o}, 32'h0000_000F);
    bus.st_addr_i = 32'h8000_0010;
    #1;
    chk("t2_head_word_no_merge", {31'd0, bus.st_ready_o}, 32'd0);
    bus.st_valid_i = 1'b0;
    expect_req(32'h8000_0010, 32'h1111_1111, 4'hF, 2'd0);
    expect_req(32'h0000_0010, 32'h0000_00AB, 4'h1, 2'd1);
    bus.mem_gnt_i = 1'b1;
    tick();
    tick();
    bus.mem_gnt_i = 1'b0;
    chk("t2_req_idle", {31'd0, bus.mem_req_o}, 32'd0);
    bus.st_addr_i = 32'h0000_0014;
    #1;
    chk("t2_inflight_ready", {31'd0, bus.st_ready_o}, 32'd0);

    // 4: acks out of order
    do_ack(2'd1);
    chk("t4_empty_after_1st", {31'd0, bus.empty_o}, 32'd0);
    chk("t4_ready_after_1st", {31'd0, bus.st_ready_o}, 32'd1);
    do_ack(2'd0);
    chk("t4_empty_after_2nd", {31'd0, bus.empty_o}, 32'd1);

    // 3: merge two half-word stores while the head is busy
    do_store(32'h8000_0030, 32'h5555_5555, 4'hF);
    do_store(32'h0000_0020, 32'h0000_1122, 4'h3);
    do_store(32'h0000_0020, 32'h3344_0000, 4'hC);
    bus.ld_addr_i = 32'h0000_0022;
    #1;
    chk("t3_ld_hit",  {31'd0, bus.ld_hit_o}, 32'd1);
    chk("t3_ld_be",   {28'd0, bus.ld_fwd_be_o}, FWD ? 32'h0000_000F : 32'd0);
    chk("t3_ld_data", bus.ld_data_o, FWD ? 32'h3344_1122 : 32'd0);
    bus.ld_addr_i = 32'h0000_0024;
    #1;
    chk("t3_ld_miss", {31'd0, bus.ld_hit_o}, 32'd0);
    expect_req(32'h8000_0030, 32'h5555_5555, 4'hF, 2'd0);
    expect_req(32'h0000_0020, 32'h3344_1122, 4'hF, 2'd1);
    bus.mem_gnt_i = 1'b1;
    tick();
    tick();
    bus.mem_gnt_i = 1'b0;
    do_ack(2'd0);
    do_ack(2'd1);
    chk("t3_empty", {31'd0, bus.empty_o}, 32'd1);

    // Same-cycle grant and ack; freed entry and TID reused next cycle
    do_store(32'h0000_0100, 32'hCAFE_F00D, 4'hF);
    expect_req(32'h0000_0100, 32'hCAFE_F00D, 4'hF, 2'd0);
    bus.mem_gnt_i = 1'b1;
    tick();
    bus.mem_gnt_i = 1'b0;
    do_store(32'h0000_0104, 32'h1234_5678, 4'hF);
    expect_req(32'h0000_0104, 32'h1234_5678, 4'hF, 2'd1);
    bus.mem_gnt_i     = 1'b1;
    bus.mem_ack_i     = 1'b1;
    bus.mem_ack_tid_i = 2'd0;
    tick();
    bus.mem_gnt_i = 1'b0;
    bus.mem_ack_i = 1'b0;
    chk("sc_ready_after_ack", {31'd0, bus.st_ready_o}, 32'd1);
    chk("sc_req_idle",        {31'd0, bus.mem_req_o}, 32'd0);
    do_store(32'h0000_0108, 32'h9ABC_DEF0, 4'hF);
    chk("sc_tid_reuse", {30'd0, bus.mem_tid_o}, 32'd0);
    expect_req(32'h0000_0108, 32'h9ABC_DEF0, 4'hF, 2'd0);
    bus.mem_gnt_i = 1'b1;
    tick();
    bus.mem_gnt_i = 1'b0;
    do_ack(2'd1);
    do_ack(2'd0);
    chk("sc_empty", {31'd0, bus.empty_o}, 32'd1);

    // 6: reset with two INFLIGHT entries, then a stale ack
    do_store(32'h0000_0200, 32'hDEAD_BEEF, 4'hF);
    expect_req(32'h0000_0200, 32'hDEAD_BEEF, 4'hF, 2'd0);
    bus.mem_gnt_i = 1'b1;
    tick();
    bus.mem_gnt_i = 1'b0;
    do_store(32'h0000_0204, 32'h0BAD_CAFE, 4'hF);
    expect_req(32'h0000_0204, 32'h0BAD_CAFE, 4'hF, 2'd1);
    bus.mem_gnt_i = 1'b1;
    tick();
    bus.mem_gnt_i = 1'b0;
    bus.ld_addr_i = 32'h0000_0200;
    #1;
    chk("t6_full_before_rst", {31'd0, bus.st_ready_o}, 32'd0);
    chk("t6_hit_before_rst",  {31'd0, bus.ld_hit_o}, 32'd1);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    do_ack(2'd0);
    #1;
    chk("t6_empty",    {31'd0, bus.empty_o}, 32'd1);
    chk("t6_req",      {31'd0, bus.mem_req_o}, 32'd0);
    chk("t6_ready",    {31'd0, bus.st_ready_o}, 32'd1);
    chk("t6_ld_hit",   {31'd0, bus.ld_hit_o}, 32'd0);
    chk("t6_mem_addr", bus.mem_addr_o, 32'd0);

    tick();
    tick();
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
